// File: rtl/float_divider_bf16_if.sv
// Operand/result handshake bundle for the sequential bf16 divider.
interface float_divider_bf16_if;
  logic [15:0] a;
  logic [15:0] b;
  logic        start;
  logic        busy;
  logic [15:0] y;
  logic        is_output_valid;

  modport master (output a, b, start, input busy, y, is_output_valid);
  modport slave  (input a, b, start, output busy, y, is_output_valid);
endinterface

// File: rtl/float_divider_bf16.sv
// Sequential bf16 divider y = a / b using restoring division, one quotient bit per cycle.
// Define FLOAT_DIVIDER_BF16_RNE_EN for round-to-nearest-even; otherwise the quotient is truncated.
module float_divider_bf16 #(
  parameter logic [7:0] BIAS  = 8'd127,
  parameter int         QBITS = 11
) (
  input  logic                 clock,
  input  logic                 reset,
  float_divider_bf16_if.slave  io
);
  typedef enum logic [1:0] {IDLE, SPECIAL, DIVIDE, ROUND} state_t;

  state_t             state_reg;
  logic               sign_reg;
  logic [7:0]         ea_reg;
  logic [7:0]         eb_reg;
  logic [7:0]         mb_reg;
  logic [9:0]         rem_reg;
  logic [QBITS-1:0]   q_reg;
  logic [3:0]         cnt_reg;
  logic               busy_reg;
  logic               valid_reg;
  logic [15:0]        y_reg;

  logic [9:0]         rem_diff;
  logic               rem_ge;
  logic signed [9:0]  e_base;
  logic signed [9:0]  e_norm;
  logic signed [9:0]  e_final;
  logic [6:0]         mant_trunc;
  logic [6:0]         mant_final;
  logic [15:0]        round_y;
`ifdef FLOAT_DIVIDER_BF16_RNE_EN
  logic               guard_bit;
  logic               round_bit;
  logic               sticky_bit;
  logic               round_up;
  logic [7:0]         mant_sum;
`endif

  assign io.busy            = busy_reg;
  assign io.y               = y_reg;
  assign io.is_output_valid = valid_reg;

  assign rem_ge   = rem_reg >= {2'b00, mb_reg};
  assign rem_diff = rem_reg - {2'b00, mb_reg};

  always_comb begin
    e_base = $signed({2'b00, ea_reg}) - $signed({2'b00, eb_reg}) + $signed({2'b00, BIAS});
`ifdef FLOAT_DIVIDER_BF16_RNE_EN
    guard_bit  = 1'b0;
    round_bit  = 1'b0;
    sticky_bit = 1'b0;
`endif
    // Quotient lies in [0.5, 2): a clear top bit means one extra normalising shift.
    if (q_reg[QBITS-1]) begin
      mant_trunc = q_reg[QBITS-2 -: 7];
      e_norm     = e_base;
`ifdef FLOAT_DIVIDER_BF16_RNE_EN
      guard_bit  = q_reg[2];
      round_bit  = q_reg[1];
      sticky_bit = q_reg[0] | (rem_reg != 10'd0);
`endif
    end else begin
      mant_trunc = q_reg[QBITS-3 -: 7];
      e_norm     = e_base - 10'sd1;
`ifdef FLOAT_DIVIDER_BF16_RNE_EN
      guard_bit  = q_reg[1];
      round_bit  = q_reg[0];
      sticky_bit = (rem_reg != 10'd0);
`endif
    end
`ifdef FLOAT_DIVIDER_BF16_RNE_EN
    round_up = guard_bit & (round_bit | sticky_bit | mant_trunc[0]);
    mant_sum = {1'b0, mant_trunc} + {7'd0, round_up};
    if (mant_sum[7]) begin
      mant_final = 7'd0;
      e_final    = e_norm + 10'sd1;
    end else begin
      mant_final = mant_sum[6:0];
      e_final    = e_norm;
    end
`else
    mant_final = mant_trunc;
    e_final    = e_norm;
`endif
    if (e_final <= 10'sd0) begin
      round_y = {sign_reg, 15'h0000};
    end else if (e_final >= 10'sd255) begin
      round_y = {sign_reg, 8'hFF, 7'h00};
    end else begin
      round_y = {sign_reg, e_final[7:0], mant_final};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      sign_reg  <= 1'b0;
      ea_reg    <= 8'd0;
      eb_reg    <= 8'd0;
      mb_reg    <= 8'd0;
      rem_reg   <= 10'd0;
      q_reg     <= '0;
      cnt_reg   <= 4'd0;
      busy_reg  <= 1'b0;
      valid_reg <= 1'b0;
      y_reg     <= 16'h0000;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (io.start) begin
            sign_reg  <= io.a[15] ^ io.b[15];
            ea_reg    <= io.a[14:7];
            eb_reg    <= io.b[14:7];
            mb_reg    <= {1'b1, io.b[6:0]};
            rem_reg   <= {2'b01, io.a[6:0]};
            q_reg     <= '0;
            cnt_reg   <= 4'(QBITS - 1);
            busy_reg  <= 1'b1;
            state_reg <= (io.a[14:7] == 8'd0 || io.b[14:7] == 8'd0) ? SPECIAL : DIVIDE;
          end
        end
        SPECIAL: begin
          // A zero dividend wins over a zero divisor, so 0/0 yields signed zero.
          y_reg     <= (ea_reg == 8'd0) ? {sign_reg, 15'h0000} : {sign_reg, 8'hFF, 7'h00};
          valid_reg <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        DIVIDE: begin
          if (rem_ge) begin
            q_reg   <= {q_reg[QBITS-2:0], 1'b1};
            rem_reg <= {rem_diff[8:0], 1'b0};
          end else begin
            q_reg   <= {q_reg[QBITS-2:0], 1'b0};
            rem_reg <= {rem_reg[8:0], 1'b0};
          end
          cnt_reg <= cnt_reg - 4'd1;
          if (cnt_reg == 4'd0) state_reg <= ROUND;
        end
        ROUND: begin
          y_reg     <= round_y;
          valid_reg <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_float_divider_bf16.sv
// Self-checking bench for float_divider_bf16: directed cases plus random operands against a reference model.
module tb_float_divider_bf16;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  float_divider_bf16_if io ();
  float_divider_bf16 dut (.clock(clock), .reset(reset), .io(io));

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer quotient of the significands, then normalise and round.
  function automatic logic [15:0] ref_div(input logic [15:0] x, input logic [15:0] z);
    logic        sgn;
    int unsigned num, den, qv, rv, mant, g, r, s;
    int          e;
    sgn = x[15] ^ z[15];
    if (x[14:7] == 8'd0) return {sgn, 15'h0000};
    if (z[14:7] == 8'd0) return {sgn, 8'hFF, 7'h00};
    num = (32'd128 + 32'(x[6:0])) * 1024;
    den = 32'd128 + 32'(z[6:0]);
    qv  = num / den;
    rv  = num % den;
    e   = int'(x[14:7]) - int'(z[14:7]) + 127;
    if (qv >= 1024) begin
      mant = (qv / 8) % 128; g = (qv / 4) % 2; r = (qv / 2) % 2; s = ((qv % 2) != 0 || rv != 0) ? 1 : 0;
    end else begin
      mant = (qv / 4) % 128; g = (qv / 2) % 2; r = qv % 2; s = (rv != 0) ? 1 : 0;
      e = e - 1;
    end
`ifdef FLOAT_DIVIDER_BF16_RNE_EN
    if (g == 1 && (r == 1 || s == 1 || (mant % 2) == 1)) mant = mant + 1;
    if (mant == 128) begin
      mant = 0;
      e = e + 1;
    end
`else
    g = 0; r = 0; s = g + r;
    mant = mant + s;
`endif
    if (e <= 0) return {sgn, 15'h0000};
    if (e >= 255) return {sgn, 8'hFF, 7'h00};
    return {sgn, 8'(e), 7'(mant)};
  endfunction

  // One operation; optionally asserts start again at cycle poke_at while busy.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tbv, input int poke_at,
                       output int lat, output logic [15:0] yv, output logic busy_mid, output logic busy_end);
    @(negedge clock);
    io.a = ta; io.b = tbv; io.start = 1'b1;
    @(posedge clock); #1;
    io.start = 1'b0; io.a = 16'($urandom); io.b = 16'($urandom);
    lat = 0; busy_mid = 1'b0;
    while (lat < 40) begin
      @(posedge clock); #1;
      lat++;
      if (lat == 1) busy_mid = io.busy;
      if (io.is_output_valid) break;
      io.start = (lat == poke_at);
    end
    io.start = 1'b0;
    yv = io.y;
    busy_end = io.busy;
  endtask

  task automatic run_case(input string tag, input logic [15:0] ta, input logic [15:0] tbv,
                          input logic [15:0] exp_y, input int poke_at);
    int          lat;
    logic [15:0] yv;
    logic        bm, be;
    bit          special;
    special = (ta[14:7] == 8'd0) || (tbv[14:7] == 8'd0);
    do_op(ta, tbv, poke_at, lat, yv, bm, be);
    $display("op %s a=%h b=%h y=%h expected=%h latency=%0d", tag, ta, tbv, yv, exp_y, lat);
    check({tag, "_y"}, yv, exp_y);
    check({tag, "_lat"}, 16'(lat), special ? 16'd1 : 16'd12);
    check({tag, "_busy_end"}, {15'd0, be}, 16'd0);
    if (!special) check({tag, "_busy_mid"}, {15'd0, bm}, 16'd1);
  endtask

  initial begin
    int          pulses;
    int          n;
    logic [15:0] ra, rb;
    io.a = 16'h0000; io.b = 16'h0000; io.start = 1'b0;

    #12;
    check("reset_y", io.y, 16'h0000);
    check("reset_busy", {15'd0, io.busy}, 16'd0);
    check("reset_valid", {15'd0, io.is_output_valid}, 16'd0);
    @(negedge clock); reset = 1'b0;

    run_case("six_by_two", 16'h40C0, 16'h4000, 16'h4040, 0);
    @(negedge clock);
    check("busy_after_valid", {15'd0, io.busy}, 16'd0);
`ifdef FLOAT_DIVIDER_BF16_RNE_EN
    run_case("one_third", 16'h3F80, 16'h4040, 16'h3EAB, 0);
`else
    run_case("one_third", 16'h3F80, 16'h4040, 16'h3EAA, 0);
`endif
    run_case("neg_by_half", 16'hBF80, 16'h3F00, 16'hC000, 4);
    pulses = 0;
    repeat (20) begin
      @(posedge clock); #1;
      if (io.is_output_valid) pulses++;
    end
    check("ignored_start_pulses", 16'(pulses), 16'd0);

    run_case("neg_zero_a", 16'h8000, 16'h4000, 16'h8000, 0);
    run_case("div_by_zero", 16'h3F80, 16'h0000, 16'h7F80, 0);
    run_case("zero_by_zero", 16'h0000, 16'h0000, 16'h0000, 0);
    run_case("saturate", 16'h7F00, 16'h3E80, 16'h7F80, 0);
    run_case("flush", 16'h0080, 16'h4000, 16'h0000, 0);
    run_case("neg_result", 16'hC0C0, 16'h4000, 16'hC040, 0);

    // Abort a divide with reset; y was 0xC040 from the previous operation.
    @(negedge clock);
    io.a = 16'h40C0; io.b = 16'h4000; io.start = 1'b1;
    @(posedge clock); #1; io.start = 1'b0;
    repeat (4) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check("abort_y", io.y, 16'h0000);
    check("abort_busy", {15'd0, io.busy}, 16'd0);
    @(negedge clock); reset = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(posedge clock); #1;
      if (io.is_output_valid) pulses++;
    end
    check("abort_pulses", 16'(pulses), 16'd0);
    $display("op abort_by_reset pulses=%0d", pulses);

    // Back-to-back: second start presented in the valid cycle of the first.
    @(negedge clock);
    io.a = 16'h40C0; io.b = 16'h4000; io.start = 1'b1;
    @(posedge clock); #1; io.start = 1'b0;
    n = 0;
    while (n < 40 && !io.is_output_valid) begin
      @(posedge clock); #1; n++;
    end
    check("b2b_first_lat", 16'(n), 16'd12);
    check("b2b_first_y", io.y, 16'h4040);
    $display("op b2b_first y=%h latency=%0d", io.y, n);
    io.a = 16'h3F80; io.b = 16'h4040; io.start = 1'b1;
    @(posedge clock); #1; io.start = 1'b0;
    n = 1;
    while (n < 40 && !io.is_output_valid) begin
      @(posedge clock); #1; n++;
    end
    check("b2b_second_gap", 16'(n), 16'd13);
    check("b2b_second_y", io.y, ref_div(16'h3F80, 16'h4040));
    $display("op b2b_second y=%h gap=%0d", io.y, n);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 7) == 0) ra[14:7] = 8'd0;
      if ($urandom_range(0, 7) == 0) rb[14:7] = 8'd0;
      run_case($sformatf("rand%0d", i), ra, rb, ref_div(ra, rb), (i % 3 == 0) ? 5 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
